// File: rtl/second_chance_victim_select_if.sv
// -----------------------------------------------------------------------------
// second_chance_victim_select_if
// Bundles the request/response handshake and the touch channel of the
// second-chance victim selector.
//   evict_valid/evict_ready/evict_addr/occupied : victim request channel
//   victim_valid/victim_ready/victim_sel/victim_free : victim result channel
//   touch_valid/touch_addr/touch_sel : reference-bit update from lookup hits
// The master modport is the requesting side and the slave modport is the
// selector.
// -----------------------------------------------------------------------------
interface second_chance_victim_select_if #(
   parameter int BUCKET_SIZE = 4,
   parameter int ADDR_WIDTH  = 3
);
   logic                   evict_valid;
   logic                   evict_ready;
   logic [ADDR_WIDTH-1:0]  evict_addr;
   logic [BUCKET_SIZE-1:0] occupied;
   logic                   victim_valid;
   logic                   victim_ready;
   logic [BUCKET_SIZE-1:0] victim_sel;
   logic                   victim_free;
   logic                   touch_valid;
   logic [ADDR_WIDTH-1:0]  touch_addr;
   logic [BUCKET_SIZE-1:0] touch_sel;

   modport master (
      output evict_valid, evict_addr, occupied, victim_ready,
             touch_valid, touch_addr, touch_sel,
      input  evict_ready, victim_valid, victim_sel, victim_free
   );

   modport slave (
      input  evict_valid, evict_addr, occupied, victim_ready,
             touch_valid, touch_addr, touch_sel,
      output evict_ready, victim_valid, victim_sel, victim_free
   );
endinterface

// File: rtl/second_chance_victim_select.sv
// -----------------------------------------------------------------------------
// second_chance_victim_select
// Picks the slot of a hashtable bucket to overwrite on an insert/evict
// request: the lowest unoccupied slot if any, otherwise the second-chance
// clock victim. One reference bit per slot and one clock hand per bucket are
// kept here; lookup hits set reference bits through the touch channel.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of second_chance_victim_select_if (request, result,
//           touch channels)
// -----------------------------------------------------------------------------
module second_chance_victim_select #(
   parameter int BUCKET_SIZE = 4,
   parameter int ADDR_WIDTH  = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   second_chance_victim_select_if.slave  bus
);

   localparam int HAND_WIDTH  = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
   localparam int NUM_BUCKETS = 2 ** ADDR_WIDTH;

   localparam logic [HAND_WIDTH-1:0]  HAND_LAST = HAND_WIDTH'(BUCKET_SIZE - 1);
   localparam logic [HAND_WIDTH-1:0]  HAND_ZERO = {HAND_WIDTH{1'b0}};
   localparam logic [BUCKET_SIZE-1:0] ALL_ONES  = {BUCKET_SIZE{1'b1}};
   localparam logic [BUCKET_SIZE-1:0] ALL_ZEROS = {BUCKET_SIZE{1'b0}};
   localparam logic [BUCKET_SIZE-1:0] ONE_HOT0  = BUCKET_SIZE'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Lowest clear bit as a one-hot vector: adding one ripples through the
   // trailing ones and lands on the first zero.
   function automatic logic [BUCKET_SIZE-1:0] lowest_zero_onehot(
      input logic [BUCKET_SIZE-1:0] mask
   );
      return ~mask & (mask + ONE_HOT0);
   endfunction

   // Explicit wrap compare so non-power-of-two bucket sizes work.
   function automatic logic [HAND_WIDTH-1:0] hand_advance(
      input logic [HAND_WIDTH-1:0] hand
   );
      logic [HAND_WIDTH-1:0] nxt;
      if (hand == HAND_LAST) begin
         nxt = HAND_ZERO;
      end else begin
         nxt = hand + HAND_WIDTH'(1'b1);
      end
      return nxt;
   endfunction

   function automatic logic [BUCKET_SIZE-1:0] hand_onehot(
      input logic [HAND_WIDTH-1:0] hand
   );
      return ONE_HOT0 << hand;
   endfunction

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BUCKET_SIZE-1:0] occ_q, occ_d;
   logic [BUCKET_SIZE-1:0] sel_q, sel_d;
   logic                   free_q, free_d;
   logic                   evict_ready_q;
   logic                   victim_valid_q;
   logic [BUCKET_SIZE-1:0] ref_q  [NUM_BUCKETS];
   logic [BUCKET_SIZE-1:0] ref_d  [NUM_BUCKETS];
   logic [HAND_WIDTH-1:0]  hand_q [NUM_BUCKETS];
   logic [HAND_WIDTH-1:0]  hand_d [NUM_BUCKETS];

   logic [HAND_WIDTH-1:0]  cur_hand_s;
   logic [BUCKET_SIZE-1:0] cur_hand_oh_s;
   logic                   cur_ref_s;
   logic                   clr_en_s;
   logic                   hand_wr_s;

   // Clock-hand position and its reference bit for the latched bucket.
   always_comb begin
      cur_hand_s    = hand_q[addr_q];
      cur_hand_oh_s = hand_onehot(cur_hand_s);
      cur_ref_s     = |(ref_q[addr_q] & cur_hand_oh_s);
   end

   // Request FSM next-state and result decision.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      occ_d     = occ_q;
      sel_d     = sel_q;
      free_d    = free_q;
      clr_en_s  = 1'b0;
      hand_wr_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.evict_valid) begin
               addr_d  = bus.evict_addr;
               occ_d   = bus.occupied;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (occ_q != ALL_ONES) begin
               // Free slot available: take it without moving the hand.
               sel_d   = lowest_zero_onehot(occ_q);
               free_d  = 1'b1;
               state_d = ST_DONE;
            end else if (cur_ref_s) begin
               // Second chance: drop the reference and look at the next slot.
               clr_en_s  = 1'b1;
               hand_wr_s = 1'b1;
               state_d   = ST_SCAN;
            end else begin
               sel_d     = cur_hand_oh_s;
               free_d    = 1'b0;
               hand_wr_s = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.victim_ready) begin
               sel_d   = ALL_ZEROS;
               free_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            sel_d   = ALL_ZEROS;
            free_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reference-bit and hand update; a scan clear overrides a simultaneous
   // touch of the same bit so the scan always terminates.
   always_comb begin
      for (int b = 0; b < NUM_BUCKETS; b++) begin
         ref_d[b] = (ref_q[b]
                     | ((bus.touch_valid && (bus.touch_addr == ADDR_WIDTH'(b)))
                        ? bus.touch_sel : ALL_ZEROS))
                    & ~((clr_en_s && (addr_q == ADDR_WIDTH'(b)))
                        ? cur_hand_oh_s : ALL_ZEROS);
         hand_d[b] = (hand_wr_s && (addr_q == ADDR_WIDTH'(b)))
                     ? hand_advance(cur_hand_s) : hand_q[b];
      end
   end

   // State, latched request, per-bucket tables and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         addr_q         <= {ADDR_WIDTH{1'b0}};
         occ_q          <= ALL_ZEROS;
         sel_q          <= ALL_ZEROS;
         free_q         <= 1'b0;
         evict_ready_q  <= 1'b1;
         victim_valid_q <= 1'b0;
         for (int b = 0; b < NUM_BUCKETS; b++) begin
            ref_q[b]  <= ALL_ZEROS;
            hand_q[b] <= HAND_ZERO;
         end
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         occ_q          <= occ_d;
         sel_q          <= sel_d;
         free_q         <= free_d;
         evict_ready_q  <= (state_d == ST_IDLE);
         victim_valid_q <= (state_d == ST_DONE);
         for (int b = 0; b < NUM_BUCKETS; b++) begin
            ref_q[b]  <= ref_d[b];
            hand_q[b] <= hand_d[b];
         end
      end
   end

   assign bus.evict_ready  = evict_ready_q;
   assign bus.victim_valid = victim_valid_q;
   assign bus.victim_sel   = sel_q;
   assign bus.victim_free  = free_q;

endmodule
